// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared constants for the port-B arbiter that sits in front of the
//   16 kW x 16 dual-port RAM: word address / data widths, default
//   requester count and burst cap, plus an index-width helper.
package ram_port_arbiter_pkg;

   localparam int AW           = 14;  // 16 kW word address
   localparam int DW           = 16;  // RAM word width
   localparam int NREQ_DEF     = 3;
   localparam int MAXBURST_DEF = 16;

   // Width of an index that counts 0..n-1; never narrower than 1 bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotate-priority encoder. Scans req starting at index
//   'start' and wrapping modulo N; the first set bit wins.
//   Ports:
//     req   in   N    request vector
//     start in   IW   index searched first
//     gnt   out  N    one-hot winner (0 when req is 0)
//     idx   out  IW   index of the winner (0 when req is 0)
module rr_pick
   import ram_port_arbiter_pkg::*;
#(
   parameter int N  = NREQ_DEF,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   always_comb begin
      int  j;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(start) + k) % N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares RAM port B among NREQ requesters. One access per cycle:
//   the grant is combinational and the RAM access happens at the end
//   of the grant cycle. Round-robin after the last winner, with a lock
//   override that lets the last winner keep the port for up to
//   MAXBURST consecutive grants.
//   Ports:
//     clk, rst           clock; synchronous active-low reset
//     req/we/lock        per-requester request, write select, burst hold
//     addr/wdata         per-requester address (14b) / write data (16b), packed
//     gnt                one-hot accept strobe
//     rvalid/rdata       read return, one cycle after a read grant
//     ram_ab/dib/ceb/web RAM port B command
//     ram_dob            RAM port B read data (1-cycle latency)
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int MAXBURST = MAXBURST_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      ram_ab,
   output logic [DW-1:0]      ram_dib,
   output logic               ram_ceb,
   output logic               ram_web,
   input  logic [DW-1:0]      ram_dob
);

   localparam int              IW    = idx_w(NREQ);
   localparam int              BW    = idx_w(MAXBURST);
   localparam logic [IW-1:0]   LASTN = IW'(NREQ - 1);
   localparam logic [BW-1:0]   BMAX  = BW'(MAXBURST - 1);

   logic [IW-1:0]   last;      // index of the most recent grant
   logic [BW-1:0]   bcnt;      // lock-override grants in the current burst
   logic [NREQ-1:0] vld_pipe;  // read grants from the previous cycle

   logic [IW-1:0]   start, pick_idx, gidx;
   logic [NREQ-1:0] pick_gnt;
   logic            lock_hit;

   assign start = (last == LASTN) ? '0 : last + 1'b1;

   rr_pick #(.N(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .start (start),
      .gnt   (pick_gnt),
      .idx   (pick_idx)
   );

   // Last owner keeps the port while it holds lock and the burst cap
   // has not been reached; once capped it competes in round-robin.
   assign lock_hit = req[last] & lock[last] & (bcnt < BMAX);

   always_comb begin
      gnt  = '0;
      gidx = pick_idx;
      if (rst) begin
         if (lock_hit) begin
            gnt[last] = 1'b1;
            gidx      = last;
         end else begin
            gnt = pick_gnt;
         end
      end
   end

   always_comb begin
      ram_ab  = '0;
      ram_dib = '0;
      ram_web = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            ram_ab  = addr[i*AW +: AW];
            ram_dib = wdata[i*DW +: DW];
            ram_web = we[i];
         end
      end
   end

   assign ram_ceb = |gnt;

   // Any grant not taken through the lock override starts a new burst,
   // including a round-robin win by the previous owner after the cap.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last     <= LASTN;
         bcnt     <= '0;
         vld_pipe <= '0;
      end else begin
         vld_pipe <= gnt & ~we;
         if (ram_ceb) begin
            last <= gidx;
            bcnt <= lock_hit ? bcnt + 1'b1 : '0;
         end
      end
   end

   // Gated by rst so a read granted just before reset asserts never
   // returns data while or after reset is applied.
   assign rvalid = vld_pipe & {NREQ{rst}};
   assign rdata  = ram_dob;

endmodule
